// File: rtl/dm_port_arbiter_if.sv
// Signal bundle between the MEM-stage port, the bridge port and the data memory.
// The arbiter uses the slave side; the CPU/bridge/DM environment uses the master side.
interface dm_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        br_req;
  logic        br_we;
  logic [31:0] br_addr;
  logic [31:0] br_wdata;
  logic [3:0]  br_be;
  logic        br_ack;
  logic [31:0] br_rdata;

  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [3:0]  dm_byte_we;
  logic [31:0] dm_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output br_req, br_we, br_addr, br_wdata, br_be,
    input  br_ack, br_rdata,
    input  dm_addr, dm_wdata, dm_we, dm_byte_we,
    output dm_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  br_req, br_we, br_addr, br_wdata, br_be,
    output br_ack, br_rdata,
    output dm_addr, dm_wdata, dm_we, dm_byte_we,
    input  dm_rdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: CPU priority with a starvation counter that forces a
// bridge slot after MAX_CPU_RUN consecutive CPU wins while the bridge waits.
//
// state       | meaning
// ST_IDLE     | nobody granted last cycle
// ST_CPU_DONE | CPU granted last cycle; cpu_rvalid/cpu_rdata this cycle
// ST_BR_DONE  | bridge granted last cycle; br_ack/br_rdata this cycle, bridge ineligible
module dm_port_arbiter #(
  parameter int MAX_CPU_RUN = 4,
  parameter int CNT_W       = 4
) (
  input logic             clk,
  input logic             reset,
  dm_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CPU_DONE = 2'd1;
  localparam logic [1:0] ST_BR_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_CPU_RUN);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] starve;
  logic             br_elig;
  logic             br_win;
  logic             cpu_win;
  logic             we_sel;
  logic [3:0]       be_sel;

  // Grants are held off while reset is asserted so no write reaches DM mid-reset.
  assign br_elig = bus.br_req & (state != ST_BR_DONE);
  assign br_win  = !reset & br_elig & (!bus.cpu_req | (starve == STARVE_MAX));
  assign cpu_win = !reset & bus.cpu_req & !br_win;

  always_comb begin
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    we_sel       = 1'b0;
    be_sel       = '0;
    if (cpu_win) begin
      bus.dm_addr  = bus.cpu_addr;
      bus.dm_wdata = bus.cpu_wdata;
      we_sel       = bus.cpu_we;
      be_sel       = bus.cpu_be;
    end else if (br_win) begin
      bus.dm_addr  = bus.br_addr;
      bus.dm_wdata = bus.br_wdata;
      we_sel       = bus.br_we;
      be_sel       = bus.br_be;
    end
  end

  assign bus.dm_we      = we_sel & (cpu_win | br_win);
  assign bus.dm_byte_we = be_sel & {4{bus.dm_we}};
  assign bus.cpu_stall  = bus.cpu_req & !cpu_win;

  // Responses are dropped while reset is high; the bridge re-issues afterwards.
  assign bus.cpu_rvalid = !reset & (state == ST_CPU_DONE);
  assign bus.br_ack     = !reset & (state == ST_BR_DONE);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.dm_rdata : '0;
  assign bus.br_rdata   = bus.br_ack ? bus.dm_rdata : '0;

  always_comb begin
    state_nxt = ST_IDLE;
    if (cpu_win)
      state_nxt = ST_CPU_DONE;
    else if (br_win)
      state_nxt = ST_BR_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      starve <= '0;
    end else begin
      state <= state_nxt;
      if (br_win || !bus.br_req)
        starve <= '0;
      else if (cpu_win && br_elig && (starve != STARVE_MAX))
        starve <= starve + CNT_W'(1);
    end
  end

endmodule
